// File: rtl/mov_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mov_pkg
//  Description : Shared types and defaults for the MOV transfer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mov_pkg;

   // Sequencer states, in the order a transfer walks through them
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LATCH  = 3'd1,
      S_WRITE  = 3'd2,
      S_VERIFY = 3'd3,
      S_CLEAR  = 3'd4,
      S_DONE   = 3'd5
   } mov_state_t;

   localparam int MOV_DATA_W   = 8;
   localparam int MOV_NUM_REGS = 4;

   // Width of a register index; never narrower than one bit
   function automatic int mov_idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int MOV_IDX_W = mov_idx_w(MOV_NUM_REGS);

endpackage
`default_nettype wire

// File: rtl/mov_transfer_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mov_transfer_controller
//  Description : Copies a source register or an immediate into a destination
//                register, reads the destination back, rewrites a bounded
//                number of times on mismatch, then clears it and flags error.
//  Revision    : 1.0 - initial release
// ============================================================================
module mov_transfer_controller
   import mov_pkg::*;
#(
   parameter int NUM_REGS  = MOV_NUM_REGS,
   parameter int DATA_W    = MOV_DATA_W,
   parameter int MAX_RETRY = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           imm_en,
   input  logic [mov_idx_w(NUM_REGS)-1:0] src_sel,
   input  logic [mov_idx_w(NUM_REGS)-1:0] dst_sel,
   input  logic [DATA_W-1:0]              imm_data,
   input  logic [NUM_REGS*DATA_W-1:0]     reg_rdata,
   output logic [NUM_REGS-1:0]            reg_we,
   output logic [DATA_W-1:0]              reg_wdata,
   output logic [NUM_REGS-1:0]            reg_mismatch_rst,
   output logic                           busy,
   output logic                           done,
   output logic                           error
);

   localparam int         c_idx_w     = mov_idx_w(NUM_REGS);
   localparam logic [2:0] c_max_retry = 3'(MAX_RETRY);

   mov_state_t            r_state;
   logic [c_idx_w-1:0]    r_src;
   logic [c_idx_w-1:0]    r_dst;
   logic                  r_imm;
   logic [DATA_W-1:0]     r_hold;
   logic [2:0]            r_retry;
   logic [NUM_REGS-1:0]   r_we;
   logic [NUM_REGS-1:0]   r_clr;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;

   logic [NUM_REGS-1:0]   w_dst_onehot;
   logic [DATA_W-1:0]     w_dst_rdata;
   logic [DATA_W-1:0]     w_src_rdata;

   // One-hot decode of the latched destination and the read-back slices
   always_comb begin
      w_dst_onehot        = '0;
      w_dst_onehot[r_dst] = 1'b1;
      w_dst_rdata         = reg_rdata[r_dst*DATA_W +: DATA_W];
      w_src_rdata         = reg_rdata[r_src*DATA_W +: DATA_W];
   end

   // Transfer sequencer; strobes are registered alongside the state change
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_imm   <= 1'b0;
         r_hold  <= '0;
         r_retry <= '0;
         r_we    <= '0;
         r_clr   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_we   <= '0;
         r_clr  <= '0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LATCH;
                  r_src   <= src_sel;
                  r_dst   <= dst_sel;
                  r_imm   <= imm_en;
                  r_error <= 1'b0;
                  r_retry <= '0;
                  r_busy  <= 1'b1;
                  // The immediate is taken now so later input changes
                  // cannot leak into the running transfer.
                  if (imm_en) begin
                     r_hold <= imm_data;
                  end
               end
            end
            S_LATCH: begin
               if (!r_imm) begin
                  r_hold <= w_src_rdata;
               end
               r_we    <= w_dst_onehot;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_state <= S_VERIFY;
            end
            S_VERIFY: begin
               if (w_dst_rdata == r_hold) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_retry < c_max_retry) begin
                  r_retry <= r_retry + 3'd1;
                  r_we    <= w_dst_onehot;
                  r_state <= S_WRITE;
               end else begin
                  r_clr   <= w_dst_onehot;
                  r_state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_error <= 1'b1;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign reg_we           = r_we;
   assign reg_wdata        = r_hold;
   assign reg_mismatch_rst = r_clr;
   assign busy             = r_busy;
   assign done             = r_done;
   assign error            = r_error;

endmodule
`default_nettype wire
